operand_seq_ctrl: RTL and testbench
===================================

# operand_seq_ctrl

Sequencing controller for the calculator's operand path. It collects keypad digits into two 2-digit BCD operands and hands each operand in turn to the shared BCD-to-binary converter. It captures the binary results, then launches the downstream arithmetic unit and waits for it to finish. It sits between the keypad decoder and the converter/arithmetic datapath, and owns all error and abort handling for operand entry.

## Interface
- TIMEOUT, 255: maximum cycles spent waiting for `conv_done` before declaring an error (1..255).
- ENTER_CODE, 4'hA: key code that commits the current operand.
- CLEAR_CODE, 4'hB: key code that aborts and clears everything.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  single-cycle pulse; `key_code` is valid.
- key_code  in  4  0-9 digit, ENTER_CODE, CLEAR_CODE; any other value is ignored.
- conv_bin  in  8  binary result from the converter.
- conv_done  in  1  converter result valid (pulse or level; sampled once per conversion).
- conv_err  in  1  converter flagged an invalid BCD digit; qualified by `conv_done`.
- calc_done  in  1  arithmetic unit finished; pulse.
- bcd_out  out  8  BCD operand to the converter, {tens, units}.
- bcd_valid  out  1  one-cycle pulse requesting a conversion of `bcd_out`.
- op_a  out  8  binary operand A.
- op_b  out  8  binary operand B.
- op_start  out  1  one-cycle pulse launching the arithmetic unit.
- seq_done  out  1  one-cycle pulse when `calc_done` is accepted.
- error  out  1  sticky error flag.
- digit_cnt  out  2  digits entered for the operand currently being typed (0..2).
- state_dbg  out  3  current state encoding.

## Operation
- States and their `state_dbg` encodings: ENTER_A=0, CONV_A=1, ENTER_B=2, CONV_B=3, LAUNCH=4, WAIT_CALC=5, ERROR=6. Encoding 7 is unused and recovers to ENTER_A.
- ENTER_A/ENTER_B, digit key:
  - The operand's BCD register shifts in the digit: bcd <= {bcd[3:0], digit}.
  - `digit_cnt` increments and saturates at 2.
  - A third digit is ignored and the register is unchanged.
- ENTER_A/ENTER_B, ENTER key:
  - With `digit_cnt`=0 the key is ignored.
  - Otherwise the register drives `bcd_out` and `bcd_valid` pulses.
  - The state moves to CONV_A or CONV_B, `digit_cnt` clears, and the timeout counter clears.
- CONV_A/CONV_B:
  - Digit and ENTER keys are ignored.
  - On `conv_done` with `conv_err`=0: `conv_bin` loads into `op_a`/`op_b`, then CONV_A moves to ENTER_B and CONV_B moves to LAUNCH.
  - On `conv_done` with `conv_err`=1, the state moves to ERROR.
  - If the timeout counter reaches TIMEOUT without `conv_done`, the state moves to ERROR.
- LAUNCH: `op_start`=1 for exactly one cycle, then WAIT_CALC.
- WAIT_CALC: on `calc_done`, `seq_done` pulses and the state moves to ENTER_A. Both BCD registers clear; `op_a`/`op_b` are retained.
- ERROR: `error`=1 held. Only CLEAR leaves this state.
- CLEAR in any state:
  - State goes to ENTER_A.
  - Both BCD registers, `digit_cnt`, `op_a`, `op_b`, `error` and the timeout counter clear.
  - Any in-flight conversion result is discarded.
- Simultaneous events:
  - CLEAR beats `conv_done` and `calc_done` in the same cycle.
  - A non-CLEAR key coincident with `conv_done` is dropped.
- Widths:
  - The timeout counter is 8 bits.
  - `bcd_out` is held at the last requested operand until the next request.

## Timing
- Reset: state ENTER_A; `bcd_out`, `op_a`, `op_b`=8'h00; `bcd_valid`, `op_start`, `seq_done`, `error`=0; `digit_cnt`=0; `state_dbg`=0.
- All outputs are registered.
- A key sampled at edge N is reflected in the outputs after edge N.
- ENTER at edge N: `bcd_valid`=1 in cycle N+1 only, and `state_dbg`=1 from N+1.
- `conv_done` sampled at edge M: `op_*` updated and state advanced after M.
  - From CONV_B: `op_start` is high in cycle M+1 and the state is WAIT_CALC from M+2.
- Timeout: entering CONV at edge N with no `conv_done` gives `error`=1 after edge N+TIMEOUT.
- `rst` asserted mid-sequence returns all registers to their reset values immediately. No pulse is emitted on release.

## Test plan
- Sequence: reset; keys 4, 2, ENTER; converter returns 8'd42; keys 0, 7, ENTER; returns 8'd7; `calc_done` 3 cycles after `op_start` -> expect:
  - `bcd_out`=8'h42 then 8'h07;
  - `op_a`=42 and `op_b`=7;
  - one `op_start` pulse and one `seq_done` pulse;
  - `state_dbg` back to 0.
- Keys 1, 2, 3, ENTER -> `bcd_out`=8'h12 (third digit ignored), `digit_cnt` saturates at 2. ENTER alone in ENTER_B with `digit_cnt`=0 -> no `bcd_valid`.
- `conv_done`=1 with `conv_err`=1 in CONV_A -> `error`=1, `state_dbg`=6; digits ignored; CLEAR -> `error`=0, `state_dbg`=0, `op_a`=0.
- TIMEOUT=10 and `conv_done` never arrives -> `error` rises exactly 10 cycles after entering CONV_B.
- CLEAR coincident with `conv_done` in CONV_B -> `op_b` stays 0, no `op_start`, state ENTER_A. `rst` pulsed during WAIT_CALC -> all outputs at reset values.

Source files
------------

// File: rtl/operand_seq_ctrl.sv
// Operand entry sequencer: collects two 2-digit BCD operands from the keypad,
// converts each through the shared BCD-to-binary unit, then launches the ALU.
module operand_seq_ctrl #(
   parameter int         TIMEOUT    = 255,
   parameter logic [3:0] ENTER_CODE = 4'hA,
   parameter logic [3:0] CLEAR_CODE = 4'hB
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid_i,
   input  logic [3:0] key_code_i,
   input  logic [7:0] conv_bin_i,
   input  logic       conv_done_i,
   input  logic       conv_err_i,
   input  logic       calc_done_i,
   output logic [7:0] bcd_out_o,
   output logic       bcd_valid_o,
   output logic [7:0] op_a_o,
   output logic [7:0] op_b_o,
   output logic       op_start_o,
   output logic       seq_done_o,
   output logic       error_o,
   output logic [1:0] digit_cnt_o,
   output logic [2:0] state_dbg_o
);

   typedef enum logic [2:0] {
      S_ENTER_A   = 3'd0,
      S_CONV_A    = 3'd1,
      S_ENTER_B   = 3'd2,
      S_CONV_B    = 3'd3,
      S_LAUNCH    = 3'd4,
      S_WAIT_CALC = 3'd5,
      S_ERROR     = 3'd6
   } state_e;

   // The converter wait aborts on the edge where the counter would reach TIMEOUT.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e     state_q;
   logic [7:0] bcd_a_q;
   logic [7:0] bcd_b_q;
   logic [7:0] bcd_out_q;
   logic       bcd_valid_q;
   logic [7:0] op_a_q;
   logic [7:0] op_b_q;
   logic       op_start_q;
   logic       seq_done_q;
   logic       error_q;
   logic [1:0] digit_cnt_q;
   logic [7:0] tmo_q;

   logic is_digit;
   logic is_enter;
   logic is_clear;

   assign is_digit = key_valid_i && (key_code_i <= 4'd9);
   assign is_enter = key_valid_i && (key_code_i == ENTER_CODE);
   assign is_clear = key_valid_i && (key_code_i == CLEAR_CODE);

   // CLEAR takes priority over every other event, including converter and ALU completions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_ENTER_A;
         bcd_a_q     <= 8'h00;
         bcd_b_q     <= 8'h00;
         bcd_out_q   <= 8'h00;
         bcd_valid_q <= 1'b0;
         op_a_q      <= 8'h00;
         op_b_q      <= 8'h00;
         op_start_q  <= 1'b0;
         seq_done_q  <= 1'b0;
         error_q     <= 1'b0;
         digit_cnt_q <= 2'd0;
         tmo_q       <= 8'h00;
      end else begin
         bcd_valid_q <= 1'b0;
         op_start_q  <= 1'b0;
         seq_done_q  <= 1'b0;
         if (is_clear) begin
            state_q     <= S_ENTER_A;
            bcd_a_q     <= 8'h00;
            bcd_b_q     <= 8'h00;
            op_a_q      <= 8'h00;
            op_b_q      <= 8'h00;
            error_q     <= 1'b0;
            digit_cnt_q <= 2'd0;
            tmo_q       <= 8'h00;
         end else begin
            case (state_q)
               S_ENTER_A, S_ENTER_B: begin
                  if (is_digit && (digit_cnt_q != 2'd2)) begin
                     if (state_q == S_ENTER_A) bcd_a_q <= {bcd_a_q[3:0], key_code_i};
                     else                      bcd_b_q <= {bcd_b_q[3:0], key_code_i};
                     digit_cnt_q <= digit_cnt_q + 2'd1;
                  end else if (is_enter && (digit_cnt_q != 2'd0)) begin
                     bcd_out_q   <= (state_q == S_ENTER_A) ? bcd_a_q : bcd_b_q;
                     bcd_valid_q <= 1'b1;
                     state_q     <= (state_q == S_ENTER_A) ? S_CONV_A : S_CONV_B;
                     digit_cnt_q <= 2'd0;
                     tmo_q       <= 8'h00;
                  end
               end
               S_CONV_A, S_CONV_B: begin
                  if (conv_done_i) begin
                     if (conv_err_i) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                     end else if (state_q == S_CONV_A) begin
                        op_a_q  <= conv_bin_i;
                        state_q <= S_ENTER_B;
                     end else begin
                        op_b_q     <= conv_bin_i;
                        op_start_q <= 1'b1;
                        state_q    <= S_LAUNCH;
                     end
                  end else if (tmo_q == TMO_LAST) begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                  end else begin
                     tmo_q <= tmo_q + 8'd1;
                  end
               end
               S_LAUNCH: state_q <= S_WAIT_CALC;
               S_WAIT_CALC: begin
                  if (calc_done_i) begin
                     seq_done_q <= 1'b1;
                     state_q    <= S_ENTER_A;
                     bcd_a_q    <= 8'h00;
                     bcd_b_q    <= 8'h00;
                  end
               end
               S_ERROR: error_q <= 1'b1;
               default: state_q <= S_ENTER_A;
            endcase
         end
      end
   end

   assign bcd_out_o   = bcd_out_q;
   assign bcd_valid_o = bcd_valid_q;
   assign op_a_o      = op_a_q;
   assign op_b_o      = op_b_q;
   assign op_start_o  = op_start_q;
   assign seq_done_o  = seq_done_q;
   assign error_o     = error_q;
   assign digit_cnt_o = digit_cnt_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Self-checking bench for operand_seq_ctrl: scoreboard queues hold the expected
// conversion requests and ALU operands, popped when the DUT pulses them.
module tb_operand_seq_ctrl;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic [7:0] conv_bin = 8'h00;
   logic       conv_done = 1'b0;
   logic       conv_err = 1'b0;
   logic       calc_done = 1'b0;
   logic [7:0] bcd_out;
   logic       bcd_valid;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_start;
   logic       seq_done;
   logic       error;
   logic [1:0] digit_cnt;
   logic [2:0] state_dbg;

   int errCount = 0;
   int checkCount = 0;
   int opStartCnt = 0;
   int seqDoneCnt = 0;
   int bcdValidCnt = 0;

   logic [7:0]  bcdQ[$];
   logic [15:0] opQ[$];

   operand_seq_ctrl #(.TIMEOUT(10), .ENTER_CODE(KEY_ENTER), .CLEAR_CODE(KEY_CLEAR)) dut (
      .clk(clk), .rst(rst),
      .key_valid_i(key_valid), .key_code_i(key_code),
      .conv_bin_i(conv_bin), .conv_done_i(conv_done), .conv_err_i(conv_err),
      .calc_done_i(calc_done),
      .bcd_out_o(bcd_out), .bcd_valid_o(bcd_valid),
      .op_a_o(op_a), .op_b_o(op_b),
      .op_start_o(op_start), .seq_done_o(seq_done), .error_o(error),
      .digit_cnt_o(digit_cnt), .state_dbg_o(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] code);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic convRespond(input logic [7:0] bin, input logic err);
      @(negedge clk);
      conv_done = 1'b1;
      conv_bin  = bin;
      conv_err  = err;
      @(negedge clk);
      conv_done = 1'b0;
      conv_err  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Scoreboard monitors compare every request pulse against the queued expectation.
   always @(negedge clk) begin
      if (bcd_valid === 1'b1) begin
         bcdValidCnt++;
         if (bcdQ.size() == 0) checkOutput("bcd_valid_unexpected", 1, 0);
         else checkOutput("bcd_out", bcd_out, bcdQ.pop_front());
      end
      if (op_start === 1'b1) begin
         opStartCnt++;
         if (opQ.size() == 0) checkOutput("op_start_unexpected", 1, 0);
         else checkOutput("operands", {op_a, op_b}, opQ.pop_front());
      end
      if (seq_done === 1'b1) seqDoneCnt++;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle(2);
      checkOutput("rst_state", state_dbg, 0);
      checkOutput("rst_bcd_out", bcd_out, 8'h00);
      checkOutput("rst_ops", {op_a, op_b}, 16'h0000);
      checkOutput("rst_pulses", {bcd_valid, op_start, seq_done, error}, 4'b0000);
      checkOutput("rst_digit_cnt", digit_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Normal sequence 42 then 07
      applyStimulus(4'd4);
      applyStimulus(4'd2);
      checkOutput("cnt_two", digit_cnt, 2);
      bcdQ.push_back(8'h42);
      applyStimulus(KEY_ENTER);
      checkOutput("conv_a_state", state_dbg, 1);
      checkOutput("cnt_cleared", digit_cnt, 0);
      convRespond(8'd42, 1'b0);
      checkOutput("enter_b_state", state_dbg, 2);
      checkOutput("op_a_loaded", op_a, 8'd42);
      applyStimulus(4'd0);
      applyStimulus(4'd7);
      bcdQ.push_back(8'h07);
      opQ.push_back({8'd42, 8'd7});
      applyStimulus(KEY_ENTER);
      convRespond(8'd7, 1'b0);
      checkOutput("launch_state", state_dbg, 4);
      idle(1);
      checkOutput("wait_state", state_dbg, 5);
      checkOutput("op_start_single", op_start, 0);
      idle(1);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      checkOutput("seq_done_pulse", seq_done, 1);
      checkOutput("back_to_a", state_dbg, 0);
      idle(1);
      checkOutput("seq_done_single", seq_done, 0);
      checkOutput("ops_retained", {op_a, op_b}, {8'd42, 8'd7});
      checkOutput("op_start_count", opStartCnt, 1);
      checkOutput("seq_done_count", seqDoneCnt, 1);

      // Third digit ignored, then empty ENTER in ENTER_B
      applyStimulus(4'd1);
      applyStimulus(4'd2);
      applyStimulus(4'd3);
      checkOutput("cnt_saturate", digit_cnt, 2);
      bcdQ.push_back(8'h12);
      applyStimulus(KEY_ENTER);
      convRespond(8'd12, 1'b0);
      applyStimulus(KEY_ENTER);
      idle(1);
      checkOutput("empty_enter_state", state_dbg, 2);
      checkOutput("empty_enter_no_req", bcdValidCnt, 3);

      // Converter timeout in CONV_B
      applyStimulus(4'd5);
      bcdQ.push_back(8'h05);
      applyStimulus(KEY_ENTER);
      idle(9);
      checkOutput("tmo_before", {state_dbg, error}, {3'd3, 1'b0});
      idle(1);
      checkOutput("tmo_error", {state_dbg, error}, {3'd6, 1'b1});
      applyStimulus(4'd3);
      checkOutput("err_digit_ignored", {digit_cnt, state_dbg}, {2'd0, 3'd6});
      applyStimulus(KEY_CLEAR);
      checkOutput("clear_from_err", {state_dbg, error}, {3'd0, 1'b0});
      checkOutput("clear_ops", {op_a, op_b}, 16'h0000);

      // Converter error in CONV_A
      applyStimulus(4'd1);
      bcdQ.push_back(8'h01);
      applyStimulus(KEY_ENTER);
      convRespond(8'd99, 1'b1);
      checkOutput("conv_err", {state_dbg, error, op_a}, {3'd6, 1'b1, 8'd0});
      applyStimulus(KEY_CLEAR);
      checkOutput("clear_after_conv_err", {state_dbg, error}, {3'd0, 1'b0});

      // CLEAR coincident with conv_done in CONV_B
      applyStimulus(4'd5);
      bcdQ.push_back(8'h05);
      applyStimulus(KEY_ENTER);
      convRespond(8'd5, 1'b0);
      applyStimulus(4'd9);
      bcdQ.push_back(8'h09);
      applyStimulus(KEY_ENTER);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = KEY_CLEAR;
      conv_done = 1'b1;
      conv_bin  = 8'd9;
      @(negedge clk);
      key_valid = 1'b0;
      conv_done = 1'b0;
      checkOutput("clear_beats_conv", {state_dbg, op_a, op_b}, {3'd0, 8'd0, 8'd0});
      idle(3);
      checkOutput("no_launch_after_clear", opStartCnt, 1);

      // Reset during WAIT_CALC
      applyStimulus(4'd1);
      bcdQ.push_back(8'h01);
      applyStimulus(KEY_ENTER);
      convRespond(8'd1, 1'b0);
      applyStimulus(4'd2);
      bcdQ.push_back(8'h02);
      opQ.push_back({8'd1, 8'd2});
      applyStimulus(KEY_ENTER);
      convRespond(8'd2, 1'b0);
      idle(1);
      checkOutput("wait_before_rst", state_dbg, 5);
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_mid_state", state_dbg, 0);
      checkOutput("rst_mid_regs", {bcd_out, op_a, op_b}, 24'h000000);
      checkOutput("rst_mid_flags", {bcd_valid, op_start, seq_done, error, digit_cnt}, 6'b0);
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      checkOutput("no_pulse_on_release", {opStartCnt[7:0], seqDoneCnt[7:0]}, {8'd2, 8'd1});
      checkOutput("queues_drained", bcdQ.size() + opQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
